// File: rtl/disp_pkg.sv
// Shared types and constants for the display pixel back end.
// Holds the state type, default VGA timing, totals and pixel field offsets.
package disp_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pix_state_t;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic DEF_HS_POL = 1'b0;
    localparam logic DEF_VS_POL = 1'b0;

    // Pixel word layout {8'h00, R, G, B}
    localparam int COL_W = 8;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    function automatic int h_total(
        input int act,
        input int fp,
        input int sw,
        input int bp
    );
        return act + fp + sw + bp;
    endfunction

    function automatic int v_total(
        input int act,
        input int fp,
        input int sw,
        input int bp
    );
        return act + fp + sw + bp;
    endfunction

endpackage

// File: rtl/disp_timing.sv
// Horizontal/vertical raster counters with region and frame strobes.
// Ports: clk_i/rst_i, en_i (advance), load_i (jump to line V_ACTIVE),
//   active_o/hsync_o/vsync_o regions, fpos_o (HCNT=0,VCNT=V_ACTIVE now),
//   fpos_nxt_o (that position is next cycle), eof_o (last pixel of frame).
module disp_timing
    import disp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic load_i,
    output logic active_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic fpos_o,
    output logic fpos_nxt_o,
    output logic eof_o
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_PRE  = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             h_wrap;

    assign h_wrap = (hcnt_q == H_LAST);

    // Disabled counters sit at 0 so a later load starts from a known point.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (load_i) begin
            hcnt_d = '0;
            vcnt_d = V_ACT;
        end else if (en_i) begin
            if (h_wrap) begin
                hcnt_d = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = '0;
                end else begin
                    vcnt_d = vcnt_q + CNT_W'(1);
                end
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end else begin
            hcnt_d = '0;
            vcnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign active_o = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign hsync_o  = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    assign vsync_o  = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    assign fpos_o   = (hcnt_q == '0) && (vcnt_q == V_ACT);
    assign eof_o    = h_wrap && (vcnt_q == V_LAST);

    // Frame position reached on the coming edge: either by a load
    // or by wrapping out of the last visible line.
    assign fpos_nxt_o = load_i
                      || (en_i && h_wrap && (vcnt_q == V_PRE));

endmodule

// File: rtl/disp_pixout.sv
// Pixel-clock VGA back end: timing, FIFO pop, registered VGA outputs.
// Ports: PCK/PRST, DISPON, CLRVBLNK, FIFO_DATA/FIFO_EMPTY/FIFO_RD,
//   FRAME_START, VBLANK, FIFO_UNDER, VGA_R/G/B/HS/VS/DE.
module disp_pixout
    import disp_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = DEF_HS_POL,
    parameter logic VS_POL   = DEF_VS_POL
) (
    input  logic        PCK,
    input  logic        PRST,
    input  logic        DISPON,
    input  logic        CLRVBLNK,
    input  logic [31:0] FIFO_DATA,
    input  logic        FIFO_EMPTY,
    output logic        FIFO_RD,
    output logic        FRAME_START,
    output logic        VBLANK,
    output logic        FIFO_UNDER,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_DE
);

    pix_state_t state_q, state_d;

    logic on, load;
    logic active, hsync, vsync;
    logic fpos, fpos_nxt, eof;
    logic rd, under;
    logic unused_pad;

    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       de_q, de_d;
    logic       fs_q, fs_d;
    logic       vbl_q, vbl_d;
    logic       und_q, und_d;

    assign unused_pad = ^FIFO_DATA[31:24];

    assign on   = (state_q != OFF);
    assign load = (state_q == OFF) && DISPON;

    disp_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i      (PCK),
        .rst_i      (PRST),
        .en_i       (on),
        .load_i     (load),
        .active_o   (active),
        .hsync_o    (hsync),
        .vsync_o    (vsync),
        .fpos_o     (fpos),
        .fpos_nxt_o (fpos_nxt),
        .eof_o      (eof)
    );

    always_ff @(posedge PCK or posedge PRST) begin
        if (PRST) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OFF: begin
                if (DISPON) state_d = RUN;
            end
            RUN: begin
                if (!DISPON) state_d = DRAIN;
            end
            DRAIN: begin
                if (DISPON) begin
                    state_d = RUN;
                end else if (eof) begin
                    state_d = OFF;
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_comb begin
        rd    = on && active && !FIFO_EMPTY;
        under = on && active && FIFO_EMPTY;
        de_d  = on && active;
        r_d   = rd ? FIFO_DATA[R_LSB +: COL_W] : '0;
        g_d   = rd ? FIFO_DATA[G_LSB +: COL_W] : '0;
        b_d   = rd ? FIFO_DATA[B_LSB +: COL_W] : '0;
        hs_d  = (on && hsync) ? HS_POL : ~HS_POL;
        vs_d  = (on && vsync) ? VS_POL : ~VS_POL;
        und_d = und_q || under;
        // FRAME_START/VBLANK are registered one cycle early so they
        // line up with the frame-position counter value itself.
        fs_d  = fpos_nxt && (state_d == RUN);
        // A clear arriving while the frame position is current loses.
        vbl_d = fpos_nxt
             || (vbl_q && !(CLRVBLNK && !(on && fpos)));
    end

    always_ff @(posedge PCK or posedge PRST) begin
        if (PRST) begin
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
            vbl_q <= 1'b0;
            und_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            fs_q  <= fs_d;
            vbl_q <= vbl_d;
            und_q <= und_d;
        end
    end

    assign FIFO_RD     = rd;
    assign FRAME_START = fs_q;
    assign VBLANK      = vbl_q;
    assign FIFO_UNDER  = und_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_DE      = de_q;

endmodule

// File: tb/tb_disp_pixout.sv
// Directed bench for disp_pixout on a reduced raster (15x11).
// FWFT FIFO model serves pixw(n) for the n-th pop.
module tb_disp_pixout;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 2;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FR   = HT * VT;
    localparam int LEAD = (VT - VA) * HT;

    logic        PCK = 1'b0;
    logic        PRST;
    logic        DISPON;
    logic        CLRVBLNK;
    logic [31:0] FIFO_DATA;
    logic        FIFO_EMPTY;
    logic        FIFO_RD;
    logic        FRAME_START;
    logic        VBLANK;
    logic        FIFO_UNDER;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_DE;
    logic [23:0] rgb;

    assign rgb = {VGA_R, VGA_G, VGA_B};

    disp_pixout #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HSW),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSW),
        .V_BP     (VBP),
        .HS_POL   (1'b0),
        .VS_POL   (1'b0)
    ) dut (
        .PCK         (PCK),
        .PRST        (PRST),
        .DISPON      (DISPON),
        .CLRVBLNK    (CLRVBLNK),
        .FIFO_DATA   (FIFO_DATA),
        .FIFO_EMPTY  (FIFO_EMPTY),
        .FIFO_RD     (FIFO_RD),
        .FRAME_START (FRAME_START),
        .VBLANK      (VBLANK),
        .FIFO_UNDER  (FIFO_UNDER),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_DE      (VGA_DE)
    );

    always #5 PCK = ~PCK;

    int n_chk = 0;
    int n_err = 0;
    int idx = 0;
    int nxt = 0;
    int bad_pix = 0;

    int f_cyc, f_de, f_hsl, f_vsl, f_rd;
    int f_first_de, f_hsoff;
    logic [23:0] f_rgb0, f_rgb1;

    function automatic logic [31:0] pixw(input int i);
        if (i < 2) return 32'(i);
        return {8'h00, 8'(i * 3 + 1), 8'(i * 7 + 2), 8'(i)};
    endfunction

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One PCK cycle; ends 1 time unit after the rising edge.
    task automatic step();
        logic        rd, emp;
        logic [31:0] w;
        @(negedge PCK);
        rd  = FIFO_RD;
        emp = FIFO_EMPTY;
        @(posedge PCK);
        #1;
        if (rd) idx++;
        FIFO_DATA = pixw(idx);
        if (VGA_DE) begin
            if (emp) begin
                if (rgb !== 24'h0) bad_pix++;
            end else begin
                w = pixw(nxt);
                if (rgb !== w[23:0]) bad_pix++;
                nxt++;
            end
        end
    endtask

    // From a FRAME_START sample to the next one.
    task automatic run_frame();
        int   rise;
        logic de_p, hs_p;
        f_cyc = 0; f_de = 0; f_hsl = 0; f_vsl = 0; f_rd = 0;
        f_first_de = -1; f_hsoff = -1; rise = -1;
        f_rgb0 = '1; f_rgb1 = '1;
        de_p = VGA_DE; hs_p = VGA_HS;
        for (int k = 1; k <= 2 * FR; k++) begin
            step();
            f_cyc = k;
            if (VGA_DE) begin
                if (f_de == 0) begin
                    f_first_de = k;
                    f_rgb0 = rgb;
                end
                if (f_de == 1) f_rgb1 = rgb;
                f_de++;
            end
            if (!VGA_HS) f_hsl++;
            if (!VGA_VS) f_vsl++;
            if (FIFO_RD) f_rd++;
            if (VGA_DE && !de_p) rise = k;
            if (!VGA_HS && hs_p && rise >= 0 && f_hsoff < 0)
                f_hsoff = k - rise;
            de_p = VGA_DE;
            hs_p = VGA_HS;
            if (FRAME_START) break;
        end
    endtask

    task automatic to_fs();
        for (int k = 0; k < 2 * FR; k++) begin
            step();
            if (FRAME_START) break;
        end
        check("fs_reached", FRAME_START, 1);
    endtask

    initial begin
        int n_rd, n_zero, e, n;
        int d_de, d_fs, d_hsl, d_vsl, d_rd, t_de, t_rd;
        logic [31:0] w;

        PRST = 1'b1;
        DISPON = 1'b0;
        CLRVBLNK = 1'b0;
        FIFO_EMPTY = 1'b0;
        FIFO_DATA = pixw(0);
        repeat (3) step();
        check("rst_de", VGA_DE, 0);
        check("rst_hs", VGA_HS, 1);
        check("rst_vs", VGA_VS, 1);
        check("rst_fs", FRAME_START, 0);
        check("rst_vblank", VBLANK, 0);
        check("rst_under", FIFO_UNDER, 0);
        check("rst_rgb", rgb, 0);
        check("rst_rd", FIFO_RD, 0);

        PRST = 1'b0;
        step();
        check("off_fs", FRAME_START, 0);
        check("off_rd", FIFO_RD, 0);

        // Start: first RUN cycle carries FRAME_START and VBLANK
        DISPON = 1'b1;
        step();
        check("fs_first", FRAME_START, 1);
        check("vblank_rise", VBLANK, 1);

        run_frame();
        check("first_de_lat", f_first_de, LEAD + 1);
        check("first_rgb0", f_rgb0, 0);
        check("first_rgb1", f_rgb1, 1);
        check("f1_de_cnt", f_de, HA * VA);
        check("f1_len", f_cyc, FR);
        check("under_clear", FIFO_UNDER, 0);

        // Steady-state timing
        run_frame();
        check("f2_len", f_cyc, FR);
        check("f2_de_cnt", f_de, HA * VA);
        check("f2_hs_low", f_hsl, HSW * VT);
        check("f2_vs_low", f_vsl, VSW * HT);
        check("f2_rd_cnt", f_rd, HA * VA);
        check("f2_hs_off", f_hsoff, HA + HFP);
        check("pix_data", bad_pix, 0);

        // Underflow on pixels 1..5 of line VA-1
        repeat (LEAD + (VA - 1) * HT + 1) step();
        FIFO_EMPTY = 1'b1;
        #1;
        n_rd = 0;
        n_zero = 0;
        repeat (5) begin
            if (FIFO_RD) n_rd++;
            step();
            if (VGA_DE && rgb == 24'h0) n_zero++;
        end
        FIFO_EMPTY = 1'b0;
        check("under_rd", n_rd, 0);
        check("under_rgb0", n_zero, 5);
        check("under_flag", FIFO_UNDER, 1);
        e = nxt;
        step();
        w = pixw(e);
        check("under_next", rgb, w[23:0]);

        // VBLANK set/clear race
        to_fs();
        CLRVBLNK = 1'b1;
        step();
        CLRVBLNK = 1'b0;
        check("vblank_set_wins", VBLANK, 1);
        CLRVBLNK = 1'b1;
        step();
        CLRVBLNK = 1'b0;
        check("vblank_clear", VBLANK, 0);
        to_fs();
        check("vblank_again", VBLANK, 1);
        check("under_sticky", FIFO_UNDER, 1);
        check("pix_data2", bad_pix, 0);

        // Drop DISPON at pixel 3 of line 2
        repeat (LEAD + 2 * HT + 2) step();
        CLRVBLNK = 1'b1;
        step();
        CLRVBLNK = 1'b0;
        DISPON = 1'b0;
        check("drain_vbl_clr", VBLANK, 0);
        d_de = 0; d_fs = 0; d_hsl = 0; d_vsl = 0;
        d_rd = 0; t_de = 0; t_rd = 0;
        for (int k = 1; k <= 2 * FR; k++) begin
            step();
            if (VGA_DE) d_de++;
            if (FRAME_START) d_fs++;
            if (!VGA_HS) d_hsl++;
            if (!VGA_VS) d_vsl++;
            if (FIFO_RD) d_rd++;
            if (k > FR && VGA_DE) t_de++;
            if (k > FR && FIFO_RD) t_rd++;
        end
        check("drain_de", d_de, (HA - 3) + (VA - 3) * HA);
        check("drain_rd", d_rd, (HA - 4) + (VA - 3) * HA);
        check("drain_fs", d_fs, 0);
        check("drain_hs_low", d_hsl, (VT - 2) * HSW);
        check("drain_vs_low", d_vsl, VSW * HT);
        check("off_tail_de", t_de, 0);
        check("off_tail_rd", t_rd, 0);
        check("drain_vblank", VBLANK, 1);

        // Restart, then reset in the middle of line 1
        DISPON = 1'b1;
        step();
        check("restart_fs", FRAME_START, 1);
        repeat (LEAD + HT + 4) step();
        check("pre_rst_de", VGA_DE, 1);
        PRST = 1'b1;
        #1;
        check("prst_de", VGA_DE, 0);
        check("prst_rgb", rgb, 0);
        check("prst_hs", VGA_HS, 1);
        check("prst_vs", VGA_VS, 1);
        check("prst_rd", FIFO_RD, 0);
        check("prst_under", FIFO_UNDER, 0);
        check("prst_vblank", VBLANK, 0);
        check("prst_fs", FRAME_START, 0);
        step();
        step();
        PRST = 1'b0;
        step();
        check("rel_fs", FRAME_START, 1);
        check("rel_vblank", VBLANK, 1);
        n = -1;
        for (int k = 1; k <= 2 * FR; k++) begin
            step();
            if (VGA_DE) begin
                n = k;
                break;
            end
        end
        check("rel_lead", n, LEAD + 1);
        check("pix_data3", bad_pix, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
